bus_processor_core: RTL and testbench

//  Parametrised single-bus multi-cycle processor core: IR, register file, A/G ALU staging, timestep FSM.

---
 rtl/proc_pkg.sv | 9 +
 rtl/proc_alu.sv | 26 ++
 rtl/bus_processor_core.sv | 90 +++++++++
 tb/tb_bus_processor_core.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: opcode and timestep encodings shared by the bus processor core and its ALU.
package proc_pkg;
  localparam int OP_W = 4;
  typedef enum logic [OP_W-1:0] {
    OP_LOAD, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_NOT, OP_SHL, OP_SHR, OP_INC
  } opcode_e;
  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;
endpackage

// File: rtl/proc_alu.sv
// proc_alu: combinational ALU; carry is carry-out, borrow, or the bit shifted out.
module proc_alu import proc_pkg::*; #(
  parameter int DATA_W = 10
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_e           op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);
  always_comb begin
    {carry, result} = '0;
    case (op)
      OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  {carry, result} = {a, 1'b0};
      OP_SHR:  {result, carry} = {1'b0, a};
      OP_INC:  {carry, result} = {1'b0, a} + (DATA_W+1)'(1);
      default: ;
    endcase
  end
endmodule

// File: rtl/bus_processor_core.sv
// bus_processor_core: single-bus multi-cycle core; define PROC_FLAGS_EN to build the Z/C flag registers.
module bus_processor_core import proc_pkg::*; #(
  parameter int DATA_W = 10,
  parameter int NREG = 4,
  localparam int RSEL_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RSEL_W-1:0] peek_sel,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] reg_out,
  output logic [1:0]        tstep,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c
);
  localparam int IR_W = OP_W + 2*RSEL_W;
  tstep_e tstep_q, tstep_n;
  logic [IR_W-1:0] ir;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] a_q, g_q, alu_r;
  logic alu_c, is_alu, is_ill, wr;
  logic [OP_W-1:0] op;
  logic [RSEL_W-1:0] rx, ry;
  assign op = ir[IR_W-1 -: OP_W];
  assign rx = ir[IR_W-1-OP_W -: RSEL_W];
  assign ry = ir[RSEL_W-1:0];
  assign is_alu = op >= OP_ADD && op <= OP_INC;
  assign is_ill = op > OP_INC;
  assign tstep = tstep_q;
  assign reg_out = regs[peek_sel];
  always_ff @(posedge clk or posedge rst)
    if (rst) tstep_q <= T0;
    else tstep_q <= tstep_n;
  always_comb begin
    tstep_n = !step ? tstep_q :
              tstep_q == T0 ? T1 :
              tstep_q == T1 ? (is_alu ? T2 : T0) :
              tstep_q == T2 ? T3 : T0;
    bus = tstep_q == T0 ? in_data :
          tstep_q == T1 ? (op == OP_LOAD ? in_data : op == OP_MOV ? regs[ry] : regs[rx]) :
          tstep_q == T2 ? regs[ry] : g_q;
    wr = tstep_q == T3 || (tstep_q == T1 && (op == OP_LOAD || op == OP_MOV));
  end
  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .a(a_q), .b(bus), .op(opcode_e'(op)), .result(alu_r), .carry(alu_c)
  );
  // Every register write takes its data from the bus, so load, move and write-back share one path.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ir <= '0;
      a_q <= '0;
      g_q <= '0;
      done <= 1'b0;
      err <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (step) begin
      if (tstep_q == T0) begin
        ir <= in_data[DATA_W-1 -: IR_W];
        done <= 1'b0;
      end
      if (tstep_q == T1) begin
        a_q <= bus;
        if (!is_alu) done <= 1'b1;
        if (is_ill) err <= 1'b1;
      end
      if (tstep_q == T2) g_q <= alu_r;
      if (tstep_q == T3) done <= 1'b1;
      if (wr) regs[rx] <= bus;
    end
`ifdef PROC_FLAGS_EN
  logic z_q, c_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else if (step && tstep_q == T2) begin
      z_q <= alu_r == '0;
      c_q <= alu_c;
    end
  assign flag_z = z_q;
  assign flag_c = c_q;
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif
endmodule

// File: tb/tb_bus_processor_core.sv
// tb_bus_processor_core: directed and random instruction sequences against an arithmetic reference model.
module tb_bus_processor_core;
  localparam int MASK = 'h3FF;
  logic clk = 1'b0, rst = 1'b1, step = 1'b0;
  logic [9:0] in_data = '0;
  logic [1:0] peek_sel = '0;
  logic [9:0] bus, reg_out;
  logic [1:0] tstep;
  logic done, err, flag_z, flag_c;
  int n_run = 0, n_fail = 0;
  int m [4];
  bit err_m, z_m, c_m;

  bus_processor_core #(.DATA_W(10), .NREG(4)) dut (
    .clk(clk), .rst(rst), .step(step), .in_data(in_data), .peek_sel(peek_sel),
    .bus(bus), .reg_out(reg_out), .tstep(tstep), .done(done), .err(err),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [9:0] d);
    @(negedge clk);
    in_data = d;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      peek_sel = 2'(i);
      #1;
      chk(tag, 32'(reg_out), 32'(m[i]));
    end
  endtask

  task automatic chk_flags(input string tag);
`ifdef PROC_FLAGS_EN
    chk({tag, "_z"}, 32'(flag_z), 32'(z_m));
    chk({tag, "_c"}, 32'(flag_c), 32'(c_m));
`else
    chk({tag, "_z"}, 32'(flag_z), 32'(0));
    chk({tag, "_c"}, 32'(flag_c), 32'(0));
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = 0;
    err_m = 0;
    z_m = 0;
    c_m = 0;
  endtask

  task automatic exec(input int op, input int rx, input int ry, input logic [9:0] d);
    logic [9:0] ir;
    int a, b, r, c;
    bit alu;
    ir = {4'(op), 2'(rx), 2'(ry), 2'($urandom)};
    alu = op >= 2 && op <= 10;
    a = m[rx];
    b = m[ry];
    r = 0;
    c = 0;
    pulse(ir);
    chk("t1_step", 32'(tstep), 32'(1));
    chk("t1_done", 32'(done), 32'(0));
    in_data = d;
    #1;
    if (op <= 10) chk("t1_bus", 32'(bus), 32'(op == 0 ? int'(d) : op == 1 ? b : a));
    pulse(d);
    case (op)
      0: m[rx] = int'(d);
      1: m[rx] = b;
      2: begin r = a + b; c = r >> 10; end
      3: begin r = a - b; c = int'(a < b); end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = ~a;
      8: begin r = a << 1; c = a >> 9; end
      9: begin r = a >> 1; c = a & 1; end
      10: begin r = a + 1; c = r >> 10; end
      default: err_m = 1;
    endcase
    if (alu) begin
      r = r & MASK;
      z_m = r == 0;
      c_m = c[0];
      pulse(10'($urandom));
      chk("t3_step", 32'(tstep), 32'(3));
      chk("t3_bus", 32'(bus), 32'(r));
      pulse(10'($urandom));
      m[rx] = r;
    end
    chk("end_step", 32'(tstep), 32'(0));
    chk("end_done", 32'(done), 32'(1));
    chk("end_err", 32'(err), 32'(err_m));
    chk_regs("regs");
    chk_flags("flags");
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_step", 32'(tstep), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk_regs("rst_regs");
    chk_flags("rst_flags");
    rst = 1'b0;
    exec(0, 1, 0, 10'h155);
    exec(0, 0, 0, 10'h3FF);
    exec(0, 1, 0, 10'h002);
    exec(2, 0, 1, 10'h000);
    chk("add_wrap", 32'(m[0]), 32'(1));
    exec(0, 1, 0, 10'h0AA);
    exec(3, 1, 1, 10'h000);
    exec(2, 3, 3, 10'h000);
    exec(15, 0, 0, 10'h000);
    exec(11, 2, 1, 10'h123);
    exec(0, 2, 0, 10'h001);
    exec(1, 3, 2, 10'h000);
    // Park an ADD in T2 with step low, then reset it before any write-back.
    exec(0, 0, 0, 10'h111);
    pulse({4'd2, 2'd0, 2'd2, 2'd0});
    pulse(10'h000);
    repeat (20) @(negedge clk);
    chk("hold_step", 32'(tstep), 32'(2));
    chk("hold_done", 32'(done), 32'(0));
    chk_regs("hold_regs");
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_step", 32'(tstep), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_err", 32'(err), 32'(0));
    chk_regs("mid_rst_regs");
    @(negedge clk);
    rst = 1'b0;
    exec(0, 2, 0, 10'h001);
    exec(9, 2, 0, 10'h000);
    chk("shr_res", 32'(m[2]), 32'(0));
    exec(8, 2, 0, 10'h000);
    exec(0, 3, 0, 10'h3FF);
    exec(10, 3, 0, 10'h000);
    exec(7, 3, 0, 10'h000);
    for (int k = 0; k < 80; k++)
      exec(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           10'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
